vga_timing: RTL and testbench

- Raster timing generator for the 800x600@60 VGA output; the upstream stage of every overlay renderer (menu text, score, paddles, ball).
- Produces the current pixel coordinate (x, y) consumed by the overlay blocks.
- Overlay blocks register their pixel output, adding one clk of latency. This block therefore also emits pin-level hsync/vsync/data-enable, delayed by a parameterised number of clk cycles so they line up with the overlay pixels.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_timing_if.sv | 14 +
 rtl/vga_timing_sync_delay_line.sv | 34 +++
 rtl/vga_timing.sv | 127 ++++++++++++
 tb/tb_vga_timing.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 800x600@60 raster timing constants, coordinate type and small decode helpers
// for the VGA timing generator and its overlay consumers.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_H_FP     = 40;
    localparam int VGA_H_SYNC   = 128;
    localparam int VGA_H_BP     = 88;
    localparam int VGA_V_ACTIVE = 600;
    localparam int VGA_V_FP     = 1;
    localparam int VGA_V_SYNC   = 4;
    localparam int VGA_V_BP     = 23;
    localparam int VGA_SYNC_POS = 1;
    localparam int COORD_W      = 12;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bits_t;

    // Half-open window test lo <= v < hi.
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster coordinate bus from the timing generator to the overlay renderers.
interface vga_timing_if;
    import vga_timing_pkg::*;

    coord_t x;
    coord_t y;
    logic   active;
    logic   pix_tick;
    logic   frame_start;
    logic   line_end;

    modport master (output x, y, active, pix_tick, frame_start, line_end);
    modport slave  (input  x, y, active, pix_tick, frame_start, line_end);
endinterface

// File: rtl/vga_timing_sync_delay_line.sv
// Synchronous-reset shift register; DEPTH = 0 degenerates to a wire.
module sync_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_bypass
        logic unused_s;
        assign unused_s = &{1'b0, clk, rst};
        assign q = d;
    end else begin : g_chain
        logic [WIDTH-1:0] stage_r [DEPTH];

        // Shift one stage per clk; reset clears every stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_r[i] <= {WIDTH{1'b0}};
                end
            end else begin
                stage_r[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_r[i] <= stage_r[i-1];
                end
            end
        end

        assign q = stage_r[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel divider, x/y counters, sync/active decodes and a
// delayed pin-level sync/data-enable path aligned with the registered overlay pixels.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int SYNC_POS   = VGA_SYNC_POS,
    parameter int CLK_DIV    = 1,
    parameter int SYNC_DELAY = 1
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master raster,
    output logic         hsync_o,
    output logic         vsync_o,
    output logic         de_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((H_TOTAL - 1) > ((1 << COORD_W) - 1) || (V_TOTAL - 1) > ((1 << COORD_W) - 1)) begin : g_width_err
        $error("vga_timing: totals do not fit the coordinate width");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16 || SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_param_err
        $error("vga_timing: CLK_DIV or SYNC_DELAY out of range");
    end

    localparam coord_t     H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t     V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t     HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t     HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t     VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t     VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam coord_t     H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t     V_LAST   = coord_t'(V_TOTAL - 1);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div_r;
    coord_t     x_r;
    coord_t     y_r;
    logic       fs_r;
    logic       tick_s;
    logic       x_wrap_s;
    logic       y_wrap_s;
    sync_bits_t raw_s;
    sync_bits_t dly_s;

    assign x_wrap_s = (x_r == H_LAST);
    assign y_wrap_s = (y_r == V_LAST);

    // Pixel divider and raster counters; x/y move only on the pixel tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= 4'd0;
            x_r   <= 12'd0;
            y_r   <= 12'd0;
        end else begin
            if (tick_s) begin
                div_r <= 4'd0;
                if (x_wrap_s) begin
                    x_r <= 12'd0;
                    if (y_wrap_s) begin
                        y_r <= 12'd0;
                    end else begin
                        y_r <= y_r + 12'd1;
                    end
                end else begin
                    x_r <= x_r + 12'd1;
                end
            end else begin
                div_r <= div_r + 4'd1;
            end
        end
    end

    // Held set through reset so the first clk after release reports the frame start;
    // otherwise set only by the tick that wraps to (0,0), so it lasts one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            fs_r <= 1'b1;
        end else begin
            fs_r <= tick_s & x_wrap_s & y_wrap_s;
        end
    end

    // Decodes from the counter registers, all forced low during reset.
    always_comb begin
        tick_s = 1'b0;
        raw_s  = '{hs: 1'b0, vs: 1'b0, de: 1'b0};
        if (rst) begin
            tick_s = 1'b0;
        end else begin
            tick_s   = (div_r == DIV_LAST);
            raw_s.de = (x_r < H_VIS) && (y_r < V_VIS);
            raw_s.hs = in_window(x_r, HS_START, HS_END);
            raw_s.vs = in_window(y_r, VS_START, VS_END);
        end
    end

    sync_delay_line #(
        .WIDTH(3),
        .DEPTH(SYNC_DELAY)
    ) u_sync_delay (
        .clk(clk),
        .rst(rst),
        .d  (raw_s),
        .q  (dly_s)
    );

    assign raster.x           = x_r;
    assign raster.y           = y_r;
    assign raster.active      = raw_s.de;
    assign raster.pix_tick    = tick_s;
    assign raster.frame_start = fs_r & ~rst;
    assign raster.line_end    = tick_s & x_wrap_s;

    assign hsync_o = (SYNC_POS != 0) ? dly_s.hs : ~dly_s.hs;
    assign vsync_o = (SYNC_POS != 0) ? dly_s.vs : ~dly_s.vs;
    assign de_o    = dly_s.de;
endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: two reduced-geometry instances (different divider,
// delay and polarity) checked every clk against an arithmetic raster model.
module tb_vga_timing;
    import vga_timing_pkg::*;

    localparam int HA = 16, HFP = 4, HS = 6, HBP = 5;
    localparam int VA = 10, VFP = 1, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int DIV_A = 1, DLY_A = 0, POS_A = 1;
    localparam int DIV_B = 3, DLY_B = 2, POS_B = 0;
    localparam int RUN_CYCLES = 7000;

    typedef struct {
        int x;
        int y;
        bit active;
        bit tick;
        bit fs;
        bit le;
        bit hs_o;
        bit vs_o;
        bit de_o;
        bit [3:0] hist_entry;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs_a, vs_a, de_a, hs_b, vs_b, de_b;

    vga_timing_if ra ();
    vga_timing_if rb ();

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POS(POS_A), .CLK_DIV(DIV_A), .SYNC_DELAY(DLY_A)
    ) dut_a (
        .clk(clk), .rst(rst), .raster(ra), .hsync_o(hs_a), .vsync_o(vs_a), .de_o(de_a)
    );

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POS(POS_B), .CLK_DIV(DIV_B), .SYNC_DELAY(DLY_B)
    ) dut_b (
        .clk(clk), .rst(rst), .raster(rb), .hsync_o(hs_b), .vsync_o(vs_b), .de_o(de_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int e_cnt = 0;
    bit started = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];
    // history entries {rst, hs, vs, de}, index 0 = previous clk
    bit [3:0] hist_a [8] = '{default: 4'b1000};
    bit [3:0] hist_b [8] = '{default: 4'b1000};

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs from e = clks since the last reset edge, with the current rst.
    function automatic exp_t predict(input int e, input bit r, input int div, input int dly,
                                     input int pos, input bit [3:0] h [8]);
        exp_t o;
        int p;
        bit hs_raw, vs_raw;
        bit [2:0] d;
        bit blocked;
        p        = e / div;
        o.x      = p % HT;
        o.y      = (p / HT) % VT;
        o.active = !r && o.x < HA && o.y < VA;
        o.tick   = !r && (e % div == div - 1);
        o.fs     = !r && (e % (div * HT * VT) == 0);
        o.le     = o.tick && o.x == HT - 1;
        hs_raw   = !r && o.x >= HA + HFP && o.x < HA + HFP + HS;
        vs_raw   = !r && o.y >= VA + VFP && o.y < VA + VFP + VS;
        o.hist_entry = {r, hs_raw, vs_raw, o.active};
        if (dly == 0) begin
            d = {hs_raw, vs_raw, o.active};
        end else begin
            blocked = 1'b0;
            for (int i = 0; i < dly; i++) if (h[i][3]) blocked = 1'b1;
            d = blocked ? 3'b000 : h[dly-1][2:0];
        end
        o.hs_o = (pos != 0) ? d[2] : !d[2];
        o.vs_o = (pos != 0) ? d[1] : !d[1];
        o.de_o = d[0];
        return o;
    endfunction

    // Reference model: advance the edge count, then push this clk's expectations.
    always @(posedge clk) begin
        exp_t ea, eb;
        if (rst) begin
            e_cnt   = 0;
            started = 1'b1;
        end else begin
            e_cnt++;
        end
        #2;
        if (started) begin
            ea = predict(e_cnt, rst, DIV_A, DLY_A, POS_A, hist_a);
            eb = predict(e_cnt, rst, DIV_B, DLY_B, POS_B, hist_b);
            q_a.push_back(ea);
            q_b.push_back(eb);
            for (int i = 7; i > 0; i--) begin
                hist_a[i] = hist_a[i-1];
                hist_b[i] = hist_b[i-1];
            end
            hist_a[0] = ea.hist_entry;
            hist_b[0] = eb.hist_entry;
        end
    end

    // Monitor: compare both instances on the falling edge.
    always @(negedge clk) begin
        exp_t ea, eb;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            check("A.x", int'(ra.x), ea.x);
            check("A.y", int'(ra.y), ea.y);
            check("A.active", int'(ra.active), int'(ea.active));
            check("A.pix_tick", int'(ra.pix_tick), int'(ea.tick));
            check("A.frame_start", int'(ra.frame_start), int'(ea.fs));
            check("A.line_end", int'(ra.line_end), int'(ea.le));
            check("A.hsync_o", int'(hs_a), int'(ea.hs_o));
            check("A.vsync_o", int'(vs_a), int'(ea.vs_o));
            check("A.de_o", int'(de_a), int'(ea.de_o));
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            check("B.x", int'(rb.x), eb.x);
            check("B.y", int'(rb.y), eb.y);
            check("B.active", int'(rb.active), int'(eb.active));
            check("B.pix_tick", int'(rb.pix_tick), int'(eb.tick));
            check("B.frame_start", int'(rb.frame_start), int'(eb.fs));
            check("B.line_end", int'(rb.line_end), int'(eb.le));
            check("B.hsync_o", int'(hs_b), int'(eb.hs_o));
            check("B.vsync_o", int'(vs_b), int'(eb.vs_o));
            check("B.de_o", int'(de_b), int'(eb.de_o));
        end
    end

    // Stimulus: initial reset, one directed mid-frame reset held 3 clks, rare random resets.
    initial begin
        int hold;
        hold = 0;
        rst  = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < RUN_CYCLES; c++) begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (hold > 0) hold--;
                else rst = 1'b0;
            end else if (c == 2700) begin
                rst  = 1'b1;
                hold = 2;
            end else if (c > 3000 && $urandom_range(0, 2999) == 0) begin
                rst  = 1'b1;
                hold = int'($urandom_range(0, 2));
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
